mole_autoplayer: RTL and testbench

Autonomous player for the whack-a-mole core: decodes the core's 7-segment/dp output stream and transmits debounce-compatible button presses back into the core's button inputs. It is the opposite end of the display and button interface, used as an on-chip demo mode and as a closed-loop self-test stimulus. It also decodes the game-over score digits and counts its own hits.

---
 rtl/mole_autoplayer.sv | 204 ++++++++++++++++++++
 tb/tb_mole_autoplayer.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mole_autoplayer.sv
// Autonomous whack-a-mole player: decodes the core's segment/dp stream, presses the
// lit mole's button after a reaction delay, decodes game-over score digits and counts hits.
module mole_autoplayer #(
  parameter int REACT_CYCLES   = 3,
  parameter int HOLD_CYCLES    = 8,
  parameter int GAP_CYCLES     = 6,
  parameter int RESTART_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       auto_restart,
  input  logic [6:0] seg_in,
  input  logic       dp_in,
  output logic [7:0] btn_out,
  output logic [7:0] hits,
  output logic [3:0] cur_digit,
  output logic       digit_valid,
  output logic       digit_stb
);

  localparam int MAX_RH  = (REACT_CYCLES > HOLD_CYCLES) ? REACT_CYCLES : HOLD_CYCLES;
  localparam int MAX_GR  = (GAP_CYCLES > RESTART_CYCLES) ? GAP_CYCLES : RESTART_CYCLES;
  localparam int MAX_CYC = (MAX_RH > MAX_GR) ? MAX_RH : MAX_GR;
  localparam int CW      = $clog2(MAX_CYC + 1);

  localparam logic [CW-1:0] REACT_LD   = CW'(REACT_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LD    = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LD     = CW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] RESTART_LD = CW'(RESTART_CYCLES - 1);

  typedef enum logic [2:0] {WATCH, REACT, PRESS, RELEASE, OVER, RSTPRESS} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [2:0]    k_q, k_nxt;
  logic [7:0]    btn_nxt, hits_nxt;

  logic [6:0] seg_q, seg_prev;
  logic       dp_q, dp_prev;
  logic [2:0] zero_cnt, tgt_k;
  logic       tgt_valid;
  logic       pat_ok;
  logic [3:0] pat_digit;
  logic       new_pattern;

  // seg_prev/dp_prev hold the previous cycle's registered display for change detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q    <= 7'h7F;
      dp_q     <= 1'b1;
      seg_prev <= 7'h7F;
      dp_prev  <= 1'b1;
    end else begin
      seg_q    <= seg_in;
      dp_q     <= dp_in;
      seg_prev <= seg_q;
      dp_prev  <= dp_q;
    end
  end

  always_comb begin
    zero_cnt = 3'd0;
    tgt_k    = 3'd0;
    for (int i = 0; i < 7; i++) begin
      if (!seg_q[i]) begin
        zero_cnt = zero_cnt + 3'd1;
        tgt_k    = 3'(i);
      end
    end
    tgt_valid = dp_q && (zero_cnt == 3'd1);
  end

  always_comb begin
    pat_ok    = 1'b1;
    pat_digit = 4'd0;
    case (seg_q)
      7'b1000000: pat_digit = 4'd0;
      7'b1111001: pat_digit = 4'd1;
      7'b0100100: pat_digit = 4'd2;
      7'b0110000: pat_digit = 4'd3;
      7'b0011001: pat_digit = 4'd4;
      7'b0010010: pat_digit = 4'd5;
      7'b0000010: pat_digit = 4'd6;
      7'b1111000: pat_digit = 4'd7;
      7'b0000000: pat_digit = 4'd8;
      7'b0010000: pat_digit = 4'd9;
      default:    pat_ok    = 1'b0;
    endcase
  end

  assign new_pattern = (seg_q != seg_prev) || dp_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_digit   <= 4'd0;
      digit_valid <= 1'b0;
      digit_stb   <= 1'b0;
    end else begin
      if (pat_ok) cur_digit <= pat_digit;
      digit_valid <= pat_ok && !dp_q;
      digit_stb   <= pat_ok && !dp_q && new_pattern;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= WATCH;
      cnt     <= '0;
      k_q     <= 3'd0;
      btn_out <= 8'd0;
      hits    <= 8'd0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      k_q     <= k_nxt;
      btn_out <= btn_nxt;
      hits    <= hits_nxt;
    end
  end

  // btn_out is registered so a press starts on the same edge the FSM enters PRESS
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    k_nxt     = k_q;
    btn_nxt   = btn_out;
    hits_nxt  = hits;
    if (!en) begin
      state_nxt = WATCH;
      cnt_nxt   = '0;
      btn_nxt   = 8'd0;
    end else begin
      case (state)
        WATCH: begin
          btn_nxt = 8'd0;
          if (!dp_q) begin
            state_nxt = OVER;
            cnt_nxt   = RESTART_LD;
          end else if (tgt_valid) begin
            state_nxt = REACT;
            k_nxt     = tgt_k;
            cnt_nxt   = REACT_LD;
          end
        end
        REACT: begin
          if (!dp_q) begin
            state_nxt = OVER;
            cnt_nxt   = RESTART_LD;
          end else if (!tgt_valid) begin
            state_nxt = WATCH;
            cnt_nxt   = '0;
          end else if (tgt_k != k_q) begin
            k_nxt   = tgt_k;
            cnt_nxt = REACT_LD;
          end else if (cnt == '0) begin
            state_nxt = PRESS;
            btn_nxt   = 8'd1 << k_q;
            cnt_nxt   = HOLD_LD;
            if (hits != 8'hFF) hits_nxt = hits + 8'd1;
          end else begin
            cnt_nxt = cnt - 1'b1;
          end
        end
        PRESS, RSTPRESS: begin
          if (cnt == '0) begin
            state_nxt = RELEASE;
            btn_nxt   = 8'd0;
            cnt_nxt   = GAP_LD;
          end else begin
            cnt_nxt = cnt - 1'b1;
          end
        end
        RELEASE: begin
          btn_nxt = 8'd0;
          if (cnt == '0) state_nxt = WATCH;
          else cnt_nxt = cnt - 1'b1;
        end
        OVER: begin
          btn_nxt = 8'd0;
          if (dp_q) begin
            state_nxt = WATCH;
            cnt_nxt   = '0;
          end else if (auto_restart) begin
            if (cnt == '0) begin
              state_nxt = RSTPRESS;
              btn_nxt   = 8'h01;
              hits_nxt  = 8'd0;
              cnt_nxt   = HOLD_LD;
            end else begin
              cnt_nxt = cnt - 1'b1;
            end
          end
        end
        default: begin
          state_nxt = WATCH;
          cnt_nxt   = '0;
          btn_nxt   = 8'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mole_autoplayer.sv
// Randomized self-checking bench for mole_autoplayer; expected press timing comes from
// cycle arithmetic on the parameters and digit outputs from a lookup-table history model.
module tb_mole_autoplayer;

  localparam int R  = 3;
  localparam int H  = 8;
  localparam int G  = 6;
  localparam int RS = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       en = 1'b1;
  logic       auto_restart = 1'b0;
  logic [6:0] seg_in = 7'h7F;
  logic       dp_in = 1'b1;
  logic [7:0] btn_out, hits;
  logic [3:0] cur_digit;
  logic       digit_valid, digit_stb;

  int checks = 0;
  int errors = 0;
  int hits_exp = 0;

  logic [6:0] digit_pat [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
  logic [6:0] prefix [11] = '{7'b0110000, 7'b0110000, 7'b0110000, 7'b0100100, 7'b0100100,
                              7'b0100100, 7'b0110000, 7'b0110000, 7'h7F, 7'h7F, 7'b0100100};

  mole_autoplayer #(
    .REACT_CYCLES(R), .HOLD_CYCLES(H), .GAP_CYCLES(G), .RESTART_CYCLES(RS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .auto_restart(auto_restart),
    .seg_in(seg_in), .dp_in(dp_in), .btn_out(btn_out), .hits(hits),
    .cur_digit(cur_digit), .digit_valid(digit_valid), .digit_stb(digit_stb)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [6:0] seg, input logic dp);
    seg_in = seg;
    dp_in  = dp;
  endtask

  task automatic expect_buttons(input string tag, input int n, input int exp);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      checkOutput(tag, int'(btn_out), exp);
    end
  endtask

  function automatic logic [6:0] target_pat(input int k);
    return 7'h7F & ~(7'd1 << k);
  endfunction

  function automatic logic [6:0] invalid_pat();
    int a, b;
    a = $urandom_range(0, 6);
    do b = $urandom_range(0, 6); while (b == a);
    return 7'($urandom) & ~(7'd1 << a) & ~(7'd1 << b);
  endfunction

  function automatic int digit_of(input logic [6:0] p);
    for (int i = 0; i < 10; i++) if (digit_pat[i] == p) return i;
    return -1;
  endfunction

  // Target from WATCH: R+1 quiet samples, then H samples of the press, hit counted
  task automatic press_fresh(input string tag, input int k);
    applyStimulus(target_pat(k), 1'b1);
    expect_buttons({tag, " react"}, R + 1, 0);
    expect_buttons({tag, " press"}, H, 1 << k);
    if (hits_exp < 255) hits_exp++;
    checkOutput({tag, " hits"}, int'(hits), hits_exp);
  endtask

  initial begin
    #2000000;
    errors++;
    $display("[TB] FAIL watchdog timeout");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    int k, k2, d, hold, last_dig, dg, m_valid, m_stb;
    logic [6:0] p;
    logic pdp;
    logic [6:0] ph[$];
    bit dh[$];

    #1 rst_n = 1'b0;
    #1;
    checkOutput("reset btn", int'(btn_out), 0);
    checkOutput("reset hits", int'(hits), 0);
    checkOutput("reset digit", int'(cur_digit), 0);
    checkOutput("reset valid", int'(digit_valid), 0);
    checkOutput("reset stb", int'(digit_stb), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    expect_buttons("idle", 3, 0);

    $display("[TB] single targets and repeated target");
    for (int r = 0; r < 3; r++) begin
      k = $urandom_range(0, 6);
      press_fresh("t1", k);
      applyStimulus(7'h7F, 1'b1);
      expect_buttons("t1 gap", G, 0);
    end
    k = 3;
    press_fresh("t1 rep", k);
    expect_buttons("t1 rep spacing", G + R + 1, 0);
    expect_buttons("t1 rep press2", H, 1 << k);
    hits_exp++;
    checkOutput("t1 rep hits", int'(hits), hits_exp);
    applyStimulus(7'h7F, 1'b1);
    expect_buttons("t1 rep gap", G, 0);

    $display("[TB] target change and invalid patterns during react");
    for (int r = 0; r < 3; r++) begin
      k  = (r == 0) ? 5 : $urandom_range(0, 6);
      do k2 = (r == 0) ? 2 : $urandom_range(0, 6); while (k2 == k);
      d  = $urandom_range(1, R);
      applyStimulus(target_pat(k), 1'b1);
      expect_buttons("t2 pre", d, 0);
      applyStimulus(target_pat(k2), 1'b1);
      expect_buttons("t2 react", R + 1, 0);
      expect_buttons("t2 press", H, 1 << k2);
      hits_exp++;
      checkOutput("t2 hits", int'(hits), hits_exp);
      applyStimulus(7'h7F, 1'b1);
      expect_buttons("t2 gap", G, 0);
    end
    applyStimulus(invalid_pat(), 1'b1);
    expect_buttons("t2 invalid", 20, 0);
    checkOutput("t2 invalid hits", int'(hits), hits_exp);
    applyStimulus(target_pat($urandom_range(0, 6)), 1'b1);
    expect_buttons("t2 pre invalid", $urandom_range(1, R), 0);
    applyStimulus(invalid_pat(), 1'b1);
    expect_buttons("t2 abort", 20, 0);
    checkOutput("t2 abort hits", int'(hits), hits_exp);

    $display("[TB] hits saturation");
    applyStimulus(target_pat($urandom_range(0, 6)), 1'b1);
    repeat (5 + 18 * (255 - hits_exp) + 40) @(negedge clk);
    hits_exp = 255;
    checkOutput("sat hits", int'(hits), hits_exp);
    applyStimulus(7'h7F, 1'b1);
    repeat (40) @(negedge clk);
    checkOutput("sat hits held", int'(hits), hits_exp);
    checkOutput("sat btn idle", int'(btn_out), 0);

    $display("[TB] game over during react with auto restart");
    auto_restart = 1'b1;
    k = $urandom_range(0, 6);
    d = $urandom_range(1, R);
    applyStimulus(target_pat(k), 1'b1);
    expect_buttons("t3 pre", d, 0);
    applyStimulus(digit_pat[8], 1'b0);
    expect_buttons("t3 over wait", RS + 1, 0);
    checkOutput("t3 abort hits", int'(hits), 255);
    expect_buttons("t3 restart press", H, 8'h01);
    hits_exp = 0;
    checkOutput("t3 hits clear", int'(hits), hits_exp);
    auto_restart = 1'b0;
    expect_buttons("t3 after", G + RS + 5, 0);

    $display("[TB] game-over digit decode");
    applyStimulus(7'h7F, 1'b1);
    repeat (5) @(negedge clk);
    last_dig = -1;
    for (int m = 0; m < 60; m++) begin
      @(negedge clk);
      if (m >= 3) begin
        dg = digit_of(ph[m-2]);
        if (dg >= 0) last_dig = dg;
        m_valid = (dg >= 0 && !dh[m-2]) ? 1 : 0;
        m_stb   = (m_valid == 1 && (ph[m-2] != ph[m-3] || dh[m-3])) ? 1 : 0;
        checkOutput("dig valid", int'(digit_valid), m_valid);
        checkOutput("dig stb", int'(digit_stb), m_stb);
        if (last_dig >= 0) checkOutput("dig value", int'(cur_digit), last_dig);
      end
      if (m == 0) begin
        p = 7'h7F; pdp = 1'b1;
      end else if (m <= 11) begin
        p = prefix[m-1]; pdp = 1'b0;
      end else begin
        pdp = 1'b0;
        case ($urandom_range(0, 9))
          0, 1, 2, 3, 4, 5: p = digit_pat[$urandom_range(0, 9)];
          6, 7:             p = ph[m-1];
          8:                p = 7'h7F;
          default:          p = 7'($urandom);
        endcase
      end
      applyStimulus(p, pdp);
      ph.push_back(p);
      dh.push_back(pdp);
    end

    $display("[TB] enable drop and reset mid-press");
    applyStimulus(7'h7F, 1'b1);
    expect_buttons("t5 idle", 10, 0);
    k = $urandom_range(0, 6);
    hold = $urandom_range(1, H - 1);
    applyStimulus(target_pat(k), 1'b1);
    expect_buttons("t5 react", R + 1, 0);
    expect_buttons("t5 press", hold, 1 << k);
    hits_exp++;
    en = 1'b0;
    expect_buttons("t5 en off", 1, 0);
    checkOutput("t5 hits held", int'(hits), hits_exp);
    expect_buttons("t5 disabled", 10, 0);
    checkOutput("t5 hits still", int'(hits), hits_exp);
    en = 1'b1;
    expect_buttons("t5 rewatch", R, 0);
    expect_buttons("t5 repress", 2, 1 << k);
    hits_exp++;
    checkOutput("t5 repress hits", int'(hits), hits_exp);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst mid btn", int'(btn_out), 0);
    checkOutput("rst mid hits", int'(hits), 0);
    checkOutput("rst mid valid", int'(digit_valid), 0);
    checkOutput("rst mid digit", int'(cur_digit), 0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(7'h7F, 1'b1);
    expect_buttons("post reset", 3, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
